// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply / multiply-accumulate sequencer that owns the architectural HI/LO registers.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MADDU = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MSUBU = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic               start_ok;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_fin, prod, hilo;

    always_comb begin
        start_ok  = Start && (Op != OP_RSVD);
        in_signed = (Op == OP_MUL) || (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
        a_mag     = (in_signed && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
        b_mag     = (in_signed && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;

        // WIDTH+1-bit add keeps the carry that the shift moves into the top bit
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

`ifdef MUL_EARLY_TERM_EN
        // skipped iterations would only have shifted; apply them all at once
        acc_fin = acc_q >> cnt_q;
`else
        acc_fin = acc_q;
`endif
        prod = sign_q ? ((2*WIDTH)'(0) - acc_fin) : acc_fin;
        hilo = {hi_q, lo_q};

        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!Flush && start_ok) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    op_d     = Op;
                    sign_d   = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = {sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
`ifdef MUL_EARLY_TERM_EN
                    if ((cnt_d == '0) || (mplier_d == '0)) begin
                        state_d = S_FIN;
                    end
`else
                    if (cnt_d == '0) begin
                        state_d = S_FIN;
                    end
`endif
                end
            end
            S_FIN: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    case (op_q)
                        OP_MUL:             result_d     = prod[WIDTH-1:0];
                        OP_MULT, OP_MULTU:  {hi_d, lo_d} = prod;
                        OP_MADD, OP_MADDU:  {hi_d, lo_d} = hilo + prod;
                        OP_MSUB, OP_MSUBU:  {hi_d, lo_d} = hilo - prod;
                        default: ;
                    endcase
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // the request cycle stalls too, so the issuing instruction holds in EX
    assign Stall  = ((state_q == S_IDLE) && start_ok) || (state_q != S_IDLE);
    assign Done   = done_q;
    assign Result = result_q;
    assign HI     = hi_q;
    assign LO     = lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: hand-computed HI/LO/Result, latency, flush and reset cases.
module tb_mul_sequencer;
    localparam logic [2:0] MUL = 3'd0, MULT = 3'd1, MULTU = 3'd2, MADD = 3'd3;
    localparam logic [2:0] MADDU = 3'd4, MSUB = 3'd5, MSUBU = 3'd6, RSVD = 3'd7;

    logic        Clk, Rst_n, Start, Flush, Stall, Done;
    logic [2:0]  Op;
    logic [31:0] A, B, Result, HI, LO;

    int vectors = 0;
    int miscompares = 0;

    mul_sequencer #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Stall(Stall), .Done(Done), .Result(Result), .HI(HI), .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic nxt();
        @(negedge Clk);
        #1;
    endtask

    // Expected cycles from the Start cycle up to (not including) the Done cycle
    function automatic int exp_cyc(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int run;
        m = ((op == MUL || op == MULT || op == MADD || op == MSUB) && b[31]) ? (32'd0 - b) : b;
        run = 1;
        for (int i = 0; i < 32; i++) if (m[i]) run = i + 1;
`ifdef MUL_EARLY_TERM_EN
        return run + 2;
`else
        return (run > 0) ? 34 : 0;
`endif
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit chain, output int cyc, output int stall_lo,
                         output logic d1, output logic d2, output logic st_done,
                         output logic [31:0] hi, output logic [31:0] lo, output logic [31:0] res);
        Start = 1'b1; Op = op; A = a; B = b;
        cyc = 0; stall_lo = 0;
        #1;
        do begin
            if (Stall !== 1'b1) stall_lo++;
            cyc++;
            nxt();
        end while (Done !== 1'b1 && cyc < 200);
        d1 = Done; hi = HI; lo = LO; res = Result;
        if (!chain) begin
            Start = 1'b0;
            #1;
            st_done = Stall;
            nxt();
            d2 = Done;
        end else begin
            st_done = 1'b0;
            d2 = 1'b0;
        end
    endtask

    int cyc, slo;
    logic d1, d2, sd;
    logic [31:0] rh, rl, rr;

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = '0; B = '0;
        repeat (2) nxt();
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", Stall); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", Done); end
        vectors++; if ({HI, LO} !== 64'd0) begin miscompares++; $display("FAIL rst_hilo: got %h want 0", {HI, LO}); end
        vectors++; if (Result !== 32'd0) begin miscompares++; $display("FAIL rst_result: got %h want 0", Result); end
        Rst_n = 1'b1;
        nxt();
    endtask

    task automatic test_mult();
        do_op(MULT, 32'hFFFFFFFD, 32'd7, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (cyc !== exp_cyc(MULT, 32'd7)) begin miscompares++; $display("FAIL mult_latency: got %0d want %0d", cyc, exp_cyc(MULT, 32'd7)); end
        vectors++; if (slo !== 0) begin miscompares++; $display("FAIL mult_stall_gap: got %0d low cycles want 0", slo); end
        vectors++; if (d1 !== 1'b1 || d2 !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse: got %b%b want 10", d1, d2); end
        vectors++; if (sd !== 1'b0) begin miscompares++; $display("FAIL mult_stall_in_done: got %b want 0", sd); end
        vectors++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_hilo: got %h_%h want ffffffff_ffffffeb", rh, rl); end
    endtask

    task automatic test_multu_maddu();
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (rh !== 32'hFFFFFFFE || rl !== 32'h00000001) begin miscompares++; $display("FAIL multu_hilo: got %h_%h want fffffffe_00000001", rh, rl); end
        vectors++; if (cyc !== exp_cyc(MULTU, 32'hFFFFFFFF)) begin miscompares++; $display("FAIL multu_latency: got %0d want %0d", cyc, exp_cyc(MULTU, 32'hFFFFFFFF)); end
        do_op(MADDU, 32'd2, 32'd3, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (rh !== 32'hFFFFFFFE || rl !== 32'h00000007) begin miscompares++; $display("FAIL maddu_hilo: got %h_%h want fffffffe_00000007", rh, rl); end
    endtask

    task automatic test_msub_mul();
        do_op(MULTU, 32'd1, 32'd5, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (rh !== 32'd0 || rl !== 32'd5) begin miscompares++; $display("FAIL seed_hilo: got %h_%h want 00000000_00000005", rh, rl); end
        do_op(MSUB, 32'd3, 32'd4, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL msub_hilo: got %h_%h want ffffffff_fffffff9", rh, rl); end
        do_op(MUL, 32'hFFFFFFFE, 32'd6, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (rr !== 32'hFFFFFFF4) begin miscompares++; $display("FAIL mul_result: got %h want fffffff4", rr); end
        vectors++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL mul_hilo_kept: got %h_%h want ffffffff_fffffff9", rh, rl); end
        vectors++; if (d1 !== 1'b1 || d2 !== 1'b0) begin miscompares++; $display("FAIL mul_done_pulse: got %b%b want 10", d1, d2); end
    endtask

    // Operands and Op change mid-RUN while Start stays high; only the IDLE sample counts
    task automatic test_start_hold();
        int n, extra;
        Start = 1'b1; Op = MULTU; A = 32'd3; B = 32'd5;
        nxt();
        Op = MULT; A = 32'd7; B = 32'hFFFFFFF9;
        n = 1;
        while (Done !== 1'b1 && n < 200) begin n++; nxt(); end
        Start = 1'b0;
        vectors++; if (n !== exp_cyc(MULTU, 32'd5)) begin miscompares++; $display("FAIL hold_latency: got %0d want %0d", n, exp_cyc(MULTU, 32'd5)); end
        vectors++; if (HI !== 32'd0 || LO !== 32'd15) begin miscompares++; $display("FAIL hold_hilo: got %h_%h want 00000000_0000000f", HI, LO); end
        extra = 0;
        repeat (40) begin nxt(); if (Done === 1'b1) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL hold_reaccept: got %0d extra Done want 0", extra); end
    endtask

    task automatic test_flush();
        int dn;
`ifdef MUL_EARLY_TERM_EN
        int fc = 2;
`else
        int fc = 10;
`endif
        Start = 1'b1; Op = MULT; A = 32'd9; B = 32'd9;
        repeat (fc) nxt();
        vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL flush_run_stall: got %b want 1", Stall); end
        Flush = 1'b1; Start = 1'b0;
        nxt();
        Flush = 1'b0;
        vectors++; if (Stall !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got stall=%b done=%b want 0 0", Stall, Done); end
        dn = 0;
        repeat (40) begin nxt(); if (Done === 1'b1) dn++; end
        vectors++; if (dn !== 0) begin miscompares++; $display("FAIL flush_late_done: got %0d want 0", dn); end
        vectors++; if (HI !== 32'd0 || LO !== 32'd15) begin miscompares++; $display("FAIL flush_hilo: got %h_%h want 00000000_0000000f", HI, LO); end
    endtask

    task automatic test_ignored_requests();
        int dn, st;
        Start = 1'b1; Op = RSVD; A = 32'd3; B = 32'd3;
        #1;
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL rsvd_stall: got %b want 0", Stall); end
        dn = 0; st = 0;
        repeat (40) begin nxt(); if (Done === 1'b1) dn++; if (Stall === 1'b1) st++; end
        vectors++; if (dn !== 0 || st !== 0) begin miscompares++; $display("FAIL rsvd_ignored: got done=%0d stall=%0d want 0 0", dn, st); end
        Op = MULTU; Flush = 1'b1;
        nxt();
        Start = 1'b0; Flush = 1'b0;
        dn = 0; st = 0;
        repeat (40) begin nxt(); if (Done === 1'b1) dn++; if (Stall === 1'b1) st++; end
        vectors++; if (dn !== 0 || st !== 0) begin miscompares++; $display("FAIL idle_flush_drop: got done=%0d stall=%0d want 0 0", dn, st); end
        vectors++; if (HI !== 32'd0 || LO !== 32'd15) begin miscompares++; $display("FAIL ignored_hilo: got %h_%h want 00000000_0000000f", HI, LO); end
    endtask

    task automatic test_back_to_back();
        do_op(MULTU, 32'd2, 32'd3, 1'b1, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (d1 !== 1'b1 || rl !== 32'd6) begin miscompares++; $display("FAIL b2b_first: got done=%b lo=%h want 1 00000006", d1, rl); end
        do_op(MADDU, 32'd4, 32'd5, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (cyc !== exp_cyc(MADDU, 32'd5)) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", cyc, exp_cyc(MADDU, 32'd5)); end
        vectors++; if (rh !== 32'd0 || rl !== 32'd26) begin miscompares++; $display("FAIL b2b_hilo: got %h_%h want 00000000_0000001a", rh, rl); end
    endtask

    task automatic test_early_term();
        do_op(MULTU, 32'h12345678, 32'd1, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (cyc !== exp_cyc(MULTU, 32'd1)) begin miscompares++; $display("FAIL et_b1_latency: got %0d want %0d", cyc, exp_cyc(MULTU, 32'd1)); end
        vectors++; if (rh !== 32'd0 || rl !== 32'h12345678) begin miscompares++; $display("FAIL et_b1_hilo: got %h_%h want 00000000_12345678", rh, rl); end
        do_op(MULTU, 32'h12345678, 32'h80000000, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (cyc !== 34) begin miscompares++; $display("FAIL et_msb_latency: got %0d want 34", cyc); end
        vectors++; if (rh !== 32'h091A2B3C || rl !== 32'd0) begin miscompares++; $display("FAIL et_msb_hilo: got %h_%h want 091a2b3c_00000000", rh, rl); end
        do_op(MULT, 32'd5, 32'd0, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
        vectors++; if (cyc !== exp_cyc(MULT, 32'd0) || {rh, rl} !== 64'd0) begin miscompares++; $display("FAIL et_zero: got cyc=%0d hilo=%h want %0d 0", cyc, {rh, rl}, exp_cyc(MULT, 32'd0)); end
        do_op(MULTU, 32'h12345678, 32'h80000000, 1'b0, cyc, slo, d1, d2, sd, rh, rl, rr);
    endtask

    task automatic test_reset_mid_run();
        Start = 1'b1; Op = MULT; A = 32'd9; B = 32'd9;
        repeat (2) nxt();
        Rst_n = 1'b0; Start = 1'b0;
        #1;
        vectors++; if (Stall !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("FAIL rst_run_ctrl: got stall=%b done=%b want 0 0", Stall, Done); end
        vectors++; if ({HI, LO} !== 64'd0 || Result !== 32'd0) begin miscompares++; $display("FAIL rst_run_regs: got hilo=%h res=%h want 0 0", {HI, LO}, Result); end
        nxt();
        Rst_n = 1'b1;
        repeat (40) nxt();
        vectors++; if (Done !== 1'b0 || Stall !== 1'b0) begin miscompares++; $display("FAIL rst_run_after: got stall=%b done=%b want 0 0", Stall, Done); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_maddu();
        test_msub_mul();
        test_start_hold();
        test_flush();
        test_ignored_requests();
        test_back_to_back();
        test_early_term();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
